gcd_client: RTL and testbench

- Requester-side engine for the gcd accelerator. Drives the accelerator's operand handshake (valid/ready) and its result handshake (valid/yumi).
- Accepts one command describing an arithmetic sequence of operand pairs, issues them one at a time, and consumes each result.
- Reports the sum and count of results on a done handshake.
- Sits between a host/CSR command port and one gcd instance. It is used for bring-up, BIST and throughput measurement.

---
 rtl/gcd_client_if.sv | 44 ++++
 rtl/gcd_client.sv | 143 ++++++++++++++
 tb/tb_gcd_client.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gcd_client_if.sv
// Bundle between gcd_client, its host command port and one gcd accelerator.
// Member names are given from the client's side: _i is driven into the client,
// _o is driven by it.
interface gcd_client_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
);
    logic               cmd_v_i;
    logic               cmd_ready_o;
    logic [COUNT_W-1:0] cmd_count_i;
    logic [WIDTH-1:0]   cmd_a_i;
    logic [WIDTH-1:0]   cmd_b_i;
    logic [WIDTH-1:0]   cmd_da_i;
    logic [WIDTH-1:0]   cmd_db_i;
    logic               gcd_en_o;
    logic               gcd_v_o;
    logic               gcd_ready_i;
    logic [WIDTH-1:0]   gcd_a_o;
    logic [WIDTH-1:0]   gcd_b_o;
    logic               gcd_v_i;
    logic [WIDTH-1:0]   gcd_data_i;
    logic               gcd_yumi_o;
    logic               done_v_o;
    logic [WIDTH-1:0]   done_sum_o;
    logic [COUNT_W-1:0] done_count_o;
    logic               done_yumi_i;
    logic               error_o;

    // Client view: it drives the gcd operand port and the done port.
    modport master (
        input  cmd_v_i, cmd_count_i, cmd_a_i, cmd_b_i, cmd_da_i, cmd_db_i,
        input  gcd_ready_i, gcd_v_i, gcd_data_i, done_yumi_i,
        output cmd_ready_o, gcd_en_o, gcd_v_o, gcd_a_o, gcd_b_o, gcd_yumi_o,
        output done_v_o, done_sum_o, done_count_o, error_o
    );

    // Environment view: host, accelerator and done consumer.
    modport slave (
        output cmd_v_i, cmd_count_i, cmd_a_i, cmd_b_i, cmd_da_i, cmd_db_i,
        output gcd_ready_i, gcd_v_i, gcd_data_i, done_yumi_i,
        input  cmd_ready_o, gcd_en_o, gcd_v_o, gcd_a_o, gcd_b_o, gcd_yumi_o,
        input  done_v_o, done_sum_o, done_count_o, error_o
    );
endinterface

// File: rtl/gcd_client.sv
// gcd_client: issues an arithmetic sequence of operand pairs to one gcd
// accelerator, one pair outstanding at a time, and reports the sum and count
// of the results on a done handshake.
// Optional WAIT watchdog: define GCD_CLIENT_TIMEOUT_EN.
module gcd_client #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         reset_i,
    gcd_client_if.master bus
);
    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] n_q, n_d;
    logic [COUNT_W-1:0] k_q, k_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   da_q, da_d;
    logic [WIDTH-1:0]   db_q, db_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               error_q, error_d;
    logic [COUNT_W-1:0] k_inc;

`ifdef GCD_CLIENT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [TmoW-1:0] tmo_inc;
`endif

    assign k_inc = k_q + COUNT_W'(1);

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            n_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            da_q    <= '0;
            db_q    <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
`ifdef GCD_CLIENT_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            da_q    <= da_d;
            db_q    <= db_d;
            sum_q   <= sum_d;
            error_q <= error_d;
`ifdef GCD_CLIENT_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic: command accept, operand issue, result consume, done.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        da_d    = da_q;
        db_d    = db_q;
        sum_d   = sum_q;
        error_d = error_q;
`ifdef GCD_CLIENT_TIMEOUT_EN
        tmo_d   = tmo_q;
        tmo_inc = tmo_q + TmoW'(1);
`endif
        case (state_q)
            StIdle: begin
                if (bus.cmd_v_i) begin
                    n_d     = bus.cmd_count_i;
                    a_d     = bus.cmd_a_i;
                    b_d     = bus.cmd_b_i;
                    da_d    = bus.cmd_da_i;
                    db_d    = bus.cmd_db_i;
                    k_d     = '0;
                    sum_d   = '0;
                    error_d = 1'b0;
                    state_d = (bus.cmd_count_i == '0) ? StDone : StSend;
                end
            end
            StSend: begin
                if (bus.gcd_ready_i) begin
                    state_d = StWait;
`ifdef GCD_CLIENT_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            StWait: begin
                if (bus.gcd_v_i) begin
                    sum_d   = sum_q + bus.gcd_data_i;
                    k_d     = k_inc;
                    a_d     = a_q + da_q;
                    b_d     = b_q + db_q;
                    state_d = (k_inc == n_q) ? StDone : StSend;
                end
`ifdef GCD_CLIENT_TIMEOUT_EN
                else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TmoW'(TIMEOUT_CYCLES)) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                end
`endif
            end
            StDone: begin
                if (bus.done_yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode directly from state; cmd_ready stays low while in reset.
    always_comb begin
        bus.cmd_ready_o  = (state_q == StIdle) && !reset_i;
        bus.gcd_en_o     = (state_q != StIdle);
        bus.gcd_v_o      = (state_q == StSend);
        bus.gcd_a_o      = a_q;
        bus.gcd_b_o      = b_q;
        bus.gcd_yumi_o   = (state_q == StWait) && bus.gcd_v_i;
        bus.done_v_o     = (state_q == StDone);
        bus.done_sum_o   = sum_q;
        bus.done_count_o = k_q;
        bus.error_o      = error_q;
    end
endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client; the bench plays host, accelerator and done
// consumer, with hand-computed gcd results.
module tb_gcd_client;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    gcd_client_if #(.WIDTH(32), .COUNT_W(16)) bus ();

    gcd_client #(.WIDTH(32), .COUNT_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle, then scramble the fields.
    task automatic send_cmd(input logic [15:0] n, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] da, input logic [31:0] db);
        chk("cmd_ready_before_cmd", 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_v_i     = 1'b1;
        bus.cmd_count_i = n;
        bus.cmd_a_i     = a;
        bus.cmd_b_i     = b;
        bus.cmd_da_i    = da;
        bus.cmd_db_i    = db;
        @(negedge clk);
        bus.cmd_v_i     = 1'b0;
        bus.cmd_count_i = 16'h7777;
        bus.cmd_a_i     = 32'hDEAD_0001;
        bus.cmd_b_i     = 32'hDEAD_0002;
        bus.cmd_da_i    = 32'hDEAD_0003;
        bus.cmd_db_i    = 32'hDEAD_0004;
    endtask

    // Accept one operand pair after 'stall' cycles of backpressure, return result.
    task automatic issue_pair(input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] res, input int stall);
        int n = 0;
        while (!bus.gcd_v_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("gcd_v_o", 32'(bus.gcd_v_o), 32'd1);
        chk("gcd_en_o", 32'(bus.gcd_en_o), 32'd1);
        chk("gcd_a_o", bus.gcd_a_o, ea);
        chk("gcd_b_o", bus.gcd_b_o, eb);
        for (int i = 0; i < stall; i++) begin
            bus.gcd_ready_i = 1'b0;
            @(negedge clk);
            chk("gcd_v_o_stall", 32'(bus.gcd_v_o), 32'd1);
            chk("gcd_a_o_stall", bus.gcd_a_o, ea);
            chk("gcd_b_o_stall", bus.gcd_b_o, eb);
        end
        bus.gcd_ready_i = 1'b1;
        @(negedge clk);
        bus.gcd_ready_i = 1'b0;
        chk("gcd_v_o_in_wait", 32'(bus.gcd_v_o), 32'd0);
        chk("gcd_yumi_idle_wait", 32'(bus.gcd_yumi_o), 32'd0);
        bus.gcd_v_i    = 1'b1;
        bus.gcd_data_i = res;
        #1;
        chk("gcd_yumi_o", 32'(bus.gcd_yumi_o), 32'd1);
        @(negedge clk);
        bus.gcd_v_i    = 1'b0;
        bus.gcd_data_i = 32'h0;
    endtask

    // Check done contents, hold without consuming for 'hold' cycles, then consume.
    task automatic finish_done(input logic [31:0] sum, input logic [31:0] cnt,
                               input logic err, input int hold);
        chk("done_v_o", 32'(bus.done_v_o), 32'd1);
        chk("done_sum_o", bus.done_sum_o, sum);
        chk("done_count_o", 32'(bus.done_count_o), cnt);
        chk("error_o", 32'(bus.error_o), 32'(err));
        chk("cmd_ready_in_done", 32'(bus.cmd_ready_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_v_hold", 32'(bus.done_v_o), 32'd1);
            chk("done_sum_hold", bus.done_sum_o, sum);
            chk("done_count_hold", 32'(bus.done_count_o), cnt);
            chk("cmd_ready_hold", 32'(bus.cmd_ready_o), 32'd0);
        end
        bus.done_yumi_i = 1'b1;
        @(negedge clk);
        bus.done_yumi_i = 1'b0;
        chk("done_v_after_yumi", 32'(bus.done_v_o), 32'd0);
        chk("cmd_ready_after_yumi", 32'(bus.cmd_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_v_i     = 1'b0;
        bus.cmd_count_i = '0;
        bus.cmd_a_i     = '0;
        bus.cmd_b_i     = '0;
        bus.cmd_da_i    = '0;
        bus.cmd_db_i    = '0;
        bus.gcd_ready_i = 1'b0;
        bus.gcd_v_i     = 1'b0;
        bus.gcd_data_i  = '0;
        bus.done_yumi_i = 1'b0;

        // Reset state.
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rst_gcd_en", 32'(bus.gcd_en_o), 32'd0);
        chk("rst_gcd_v", 32'(bus.gcd_v_o), 32'd0);
        chk("rst_done_v", 32'(bus.done_v_o), 32'd0);
        chk("rst_error", 32'(bus.error_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);

        // Basic: gcd(12,18)=6 three times.
        send_cmd(16'd3, 32'd12, 32'd18, 32'd0, 32'd0);
        issue_pair(32'd12, 32'd18, 32'd6, 0);
        issue_pair(32'd12, 32'd18, 32'd6, 0);
        issue_pair(32'd12, 32'd18, 32'd6, 0);
        finish_done(32'd18, 32'd3, 1'b0, 0);

        // Stride with operand and done backpressure: 5+15+5+5=30.
        send_cmd(16'd4, 32'd10, 32'd15, 32'd5, 32'd0);
        issue_pair(32'd10, 32'd15, 32'd5, 0);
        issue_pair(32'd15, 32'd15, 32'd15, 5);
        issue_pair(32'd20, 32'd15, 32'd5, 0);
        issue_pair(32'd25, 32'd15, 32'd5, 0);
        finish_done(32'd30, 32'd4, 1'b0, 10);

        // Zero count: done the cycle after acceptance, no operand issue.
        send_cmd(16'd0, 32'd3, 32'd9, 32'd1, 32'd1);
        chk("zero_gcd_v", 32'(bus.gcd_v_o), 32'd0);
        finish_done(32'd0, 32'd0, 1'b0, 2);

        // Wrap: a goes 0xFFFFFFFF -> 0; gcd(0xFFFFFFFF,8)=1, gcd(0,8)=8.
        send_cmd(16'd2, 32'hFFFF_FFFF, 32'd8, 32'd1, 32'd0);
        issue_pair(32'hFFFF_FFFF, 32'd8, 32'd1, 0);
        issue_pair(32'h0000_0000, 32'd8, 32'd8, 0);
        finish_done(32'd9, 32'd2, 1'b0, 0);

        // Asynchronous reset mid-WAIT of an N=5 sequence.
        send_cmd(16'd5, 32'd4, 32'd6, 32'd1, 32'd1);
        chk("rstw_gcd_v", 32'(bus.gcd_v_o), 32'd1);
        bus.gcd_ready_i = 1'b1;
        @(negedge clk);
        bus.gcd_ready_i = 1'b0;
        bus.gcd_v_i     = 1'b1;
        bus.gcd_data_i  = 32'd2;
        #1;
        chk("rstw_yumi_before", 32'(bus.gcd_yumi_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstw_gcd_en", 32'(bus.gcd_en_o), 32'd0);
        chk("rstw_yumi", 32'(bus.gcd_yumi_o), 32'd0);
        chk("rstw_gcd_a", bus.gcd_a_o, 32'd0);
        chk("rstw_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rstw_done_v", 32'(bus.done_v_o), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.gcd_v_i = 1'b0;
        #1;
        chk("rstw_cmd_ready_after", 32'(bus.cmd_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw_no_done", 32'(bus.done_v_o), 32'd0);
        end

`ifdef GCD_CLIENT_TIMEOUT_EN
        // Watchdog: no result ever arrives; done after 16 WAIT cycles.
        begin
            int n = 0;
            send_cmd(16'd2, 32'd4, 32'd6, 32'd0, 32'd0);
            bus.gcd_ready_i = 1'b1;
            @(negedge clk);
            bus.gcd_ready_i = 1'b0;
            while (!bus.done_v_o && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("tmo_wait_cycles", 32'(n), 32'd16);
            bus.gcd_v_i    = 1'b1;
            bus.gcd_data_i = 32'd2;
            #1;
            chk("tmo_late_yumi", 32'(bus.gcd_yumi_o), 32'd0);
            finish_done(32'd0, 32'd0, 1'b1, 0);
            bus.gcd_v_i = 1'b0;
            send_cmd(16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            chk("tmo_error_cleared", 32'(bus.error_o), 32'd0);
            finish_done(32'd0, 32'd0, 1'b0, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
